// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and helpers for the register-file write-back buffer.
//   DBITS_DEF / ABITS_DEF : default data and register-index widths
//   wb_entry_t            : one queued write (destination index + data)
//   cnt_width()           : width of an occupancy counter that must be able
//                           to hold the value DEPTH itself
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int DBITS_DEF = 32;
   localparam int ABITS_DEF = 4;

   typedef struct packed {
      logic [ABITS_DEF-1:0] ind;
      logic [DBITS_DEF-1:0] data;
   } wb_entry_t;

   // A full queue holds DEPTH entries, so the counter needs one bit more
   // than the pointers.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wb_fifo2w.sv
// ---------------------------------------------------------------------------
// wb_fifo2w
// Circular FIFO of wb_entry_t with two write ports and one read port.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   wr0_en / wr0     : first (older) write this cycle
//   wr1_en / wr1     : second (younger) write; only asserted with wr0_en
//   pop              : drop the head entry at this edge
//   count            : number of valid entries
//   entries[DEPTH]   : entries in age order, entries[0] is the head;
//                      only the first `count` are meaningful
// ---------------------------------------------------------------------------
module wb_fifo2w
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr0_en,
   input  wb_entry_t     wr0,
   input  logic          wr1_en,
   input  wb_entry_t     wr1,
   input  logic          pop,
   output logic [CW-1:0] count,
   output wb_entry_t     entries [DEPTH]
);

   localparam int PW = $clog2(DEPTH);

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(pop);
         tail  <= tail + PW'(wr0_en) + PW'(wr1_en);
         count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
      end
   end

   // Storage is not reset; entries outside `count` are never looked at.
   always_ff @(posedge clk) begin
      if (wr0_en) mem[tail] <= wr0;
      if (wr1_en) mem[tail + PW'(1)] <= wr1;
   end

   // Present the contents rotated so index 0 is always the oldest entry.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries[i] = mem[head + PW'(i)];
      end
   end

endmodule

// File: rtl/regfile_wb_buffer.sv
// ---------------------------------------------------------------------------
// regfile_wb_buffer
// Write-back buffer in front of the register file's single write port.
// Queues ALU and load results in program order (ALU older), drains one per
// cycle, and flags/bypasses queued values on the two read ports.
// Optional feature macro: WB_BYPASS_EN (read bypass of queued data).
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   aluValid/aluInd/aluData       : ALU result
//   memValid/memInd/memData       : load result
//   ready                         : room for two entries this cycle
//   overflow                      : sticky, a result arrived while !ready
//   wrtEn/wrtInd/wrtData          : register file write port
//   rdInd0/rdInd1, rfOut0/rfOut1  : read indices and register file data
//   rdData0/rdData1               : read data to the datapath
//   hz0/hz1                       : a queued entry targets rdInd0/rdInd1
// ---------------------------------------------------------------------------
module regfile_wb_buffer
   import wb_pkg::*;
#(
   parameter int DBITS = DBITS_DEF,
   parameter int ABITS = ABITS_DEF,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             aluValid,
   input  logic [ABITS-1:0] aluInd,
   input  logic [DBITS-1:0] aluData,
   input  logic             memValid,
   input  logic [ABITS-1:0] memInd,
   input  logic [DBITS-1:0] memData,
   output logic             ready,
   output logic             overflow,
   output logic             wrtEn,
   output logic [ABITS-1:0] wrtInd,
   output logic [DBITS-1:0] wrtData,
   input  logic [ABITS-1:0] rdInd0,
   input  logic [ABITS-1:0] rdInd1,
   input  logic [DBITS-1:0] rfOut0,
   input  logic [DBITS-1:0] rfOut1,
   output logic [DBITS-1:0] rdData0,
   output logic [DBITS-1:0] rdData1,
   output logic             hz0,
   output logic             hz1
);

   localparam int CW = cnt_width(DEPTH);

   logic [CW-1:0] count;
   wb_entry_t     entries [DEPTH];
   wb_entry_t     alu_entry;
   wb_entry_t     mem_entry;
   logic          wr0_en;
   logic          wr1_en;
   wb_entry_t     wr0;

   assign alu_entry = '{ind: aluInd, data: aluData};
   assign mem_entry = '{ind: memInd, data: memData};

   assign ready = (count <= CW'(DEPTH - 2));

   // Port 0 takes the older result: ALU if present, otherwise the load.
   // Port 1 is only needed when both producers complete together.
   assign wr0_en = ready & (aluValid | memValid);
   assign wr1_en = ready & aluValid & memValid;
   assign wr0    = aluValid ? alu_entry : mem_entry;

   assign wrtEn   = (count != '0);
   assign wrtInd  = entries[0].ind;
   assign wrtData = entries[0].data;

   wb_fifo2w #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr0_en  (wr0_en),
      .wr0     (wr0),
      .wr1_en  (wr1_en),
      .wr1     (mem_entry),
      .pop     (wrtEn),
      .count   (count),
      .entries (entries)
   );

   // Sticky overflow: any result offered while not ready is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if ((aluValid | memValid) && !ready) begin
         overflow <= 1'b1;
      end
   end

   // Hazard detect over every occupied slot, head included.
   always_comb begin
      hz0 = 1'b0;
      hz1 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(count)) begin
            if (entries[i].ind == rdInd0) hz0 = 1'b1;
            if (entries[i].ind == rdInd1) hz1 = 1'b1;
         end
      end
   end

`ifdef WB_BYPASS_EN
   // Walk oldest to youngest so the youngest match overrides older ones.
   always_comb begin
      rdData0 = rfOut0;
      rdData1 = rfOut1;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(count)) begin
            if (entries[i].ind == rdInd0) rdData0 = entries[i].data;
            if (entries[i].ind == rdInd1) rdData1 = entries[i].data;
         end
      end
   end
`else
   assign rdData0 = rfOut0;
   assign rdData1 = rfOut1;
`endif

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_buffer
// Directed stimulus with a scoreboard of expected register-file writes.
// Expected read/hazard values follow WB_BYPASS_EN the same way the DUT does.
// ---------------------------------------------------------------------------
module tb_regfile_wb_buffer;
   import wb_pkg::*;

   localparam int DBITS = 32;
   localparam int ABITS = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             aluValid = 1'b0;
   logic [ABITS-1:0] aluInd = '0;
   logic [DBITS-1:0] aluData = '0;
   logic             memValid = 1'b0;
   logic [ABITS-1:0] memInd = '0;
   logic [DBITS-1:0] memData = '0;
   logic             ready;
   logic             overflow;
   logic             wrtEn;
   logic [ABITS-1:0] wrtInd;
   logic [DBITS-1:0] wrtData;
   logic [ABITS-1:0] rdInd0 = '0;
   logic [ABITS-1:0] rdInd1 = '0;
   logic [DBITS-1:0] rfOut0 = 32'h0000_0007;
   logic [DBITS-1:0] rfOut1 = 32'h0000_1111;
   logic [DBITS-1:0] rdData0;
   logic [DBITS-1:0] rdData1;
   logic             hz0;
   logic             hz1;

   wb_entry_t sb[$];
   logic      modelOverflow = 1'b0;
   int        total = 0;
   int        bad = 0;

   regfile_wb_buffer #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .aluValid (aluValid),
      .aluInd   (aluInd),
      .aluData  (aluData),
      .memValid (memValid),
      .memInd   (memInd),
      .memData  (memData),
      .ready    (ready),
      .overflow (overflow),
      .wrtEn    (wrtEn),
      .wrtInd   (wrtInd),
      .wrtData  (wrtData),
      .rdInd0   (rdInd0),
      .rdInd1   (rdInd1),
      .rfOut0   (rfOut0),
      .rfOut1   (rfOut1),
      .rdData0  (rdData0),
      .rdData1  (rdData1),
      .hz0      (hz0),
      .hz1      (hz1)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string name, input logic [DBITS-1:0] act,
                             input logic [DBITS-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Youngest queued match wins; without bypass only the hazard is modelled.
   function automatic void expectRead(input logic [ABITS-1:0] ind,
                                      input logic [DBITS-1:0] rf,
                                      output logic hz,
                                      output logic [DBITS-1:0] data);
      hz   = 1'b0;
      data = rf;
      foreach (sb[i]) begin
         if (sb[i].ind == ind) begin
            hz = 1'b1;
`ifdef WB_BYPASS_EN
            data = sb[i].data;
`endif
         end
      end
   endfunction

   // Monitor: every negedge out of reset, a write must match the oldest
   // expected entry, and an idle write port means nothing is expected.
   always @(negedge clk) begin
      if (reset_n) begin
         if (wrtEn) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_write: got ind=%0h data=%0h expected none",
                        wrtInd, wrtData);
            end else begin
               wb_entry_t e;
               e = sb.pop_front();
               checkValue("wrtInd", DBITS'(wrtInd), DBITS'(e.ind));
               checkValue("wrtData", wrtData, e.data);
            end
         end else begin
            checkValue("wrt_pending", DBITS'(sb.size()), '0);
         end
      end
   end

   // Drive one cycle of producer traffic and record what the queue accepts.
   task automatic applyStimulus(input logic av, input logic [ABITS-1:0] ai,
                                input logic [DBITS-1:0] ad, input logic mv,
                                input logic [ABITS-1:0] mi, input logic [DBITS-1:0] md);
      bit accept;
      aluValid = av; aluInd = ai; aluData = ad;
      memValid = mv; memInd = mi; memData = md;
      accept = (sb.size() <= DEPTH - 2);
      @(posedge clk);
      if (accept) begin
         if (av) sb.push_back('{ind: ai, data: ad});
         if (mv) sb.push_back('{ind: mi, data: md});
      end else if (av || mv) begin
         modelOverflow = 1'b1;
      end
      #1;
      aluValid = 1'b0;
      memValid = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic checkOutput(input string tag);
      logic             h0, h1;
      logic [DBITS-1:0] d0, d1;
      expectRead(rdInd0, rfOut0, h0, d0);
      expectRead(rdInd1, rfOut1, h1, d1);
      checkValue({tag, ".ready"},    DBITS'(ready),    DBITS'(sb.size() <= DEPTH - 2));
      checkValue({tag, ".overflow"}, DBITS'(overflow), DBITS'(modelOverflow));
      checkValue({tag, ".wrtEn"},    DBITS'(wrtEn),    DBITS'(sb.size() != 0));
      checkValue({tag, ".hz0"},      DBITS'(hz0),      DBITS'(h0));
      checkValue({tag, ".hz1"},      DBITS'(hz1),      DBITS'(h1));
      checkValue({tag, ".rdData0"},  rdData0,          d0);
      checkValue({tag, ".rdData1"},  rdData1,          d1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single ALU write to r6 read back through port 0.
      rdInd0 = 4'd6; rdInd1 = 4'd0;
      applyStimulus(1'b1, 4'd6, 32'd2, 1'b0, '0, '0);
      checkOutput("alu_r6");
      checkValue("alu_r6.hz0_direct", DBITS'(hz0), 32'd1);
`ifdef WB_BYPASS_EN
      checkValue("alu_r6.bypass", rdData0, 32'd2);
`else
      checkValue("alu_r6.nobypass", rdData0, 32'd7);
`endif
      idleCycle();
      checkOutput("alu_r6_done");

      // Same-index pair: ALU r8=5 older, load r8=33 younger.
      rdInd0 = 4'd1; rdInd1 = 4'd8;
      applyStimulus(1'b1, 4'd8, 32'd5, 1'b1, 4'd8, 32'd33);
      checkOutput("pair_r8_q2");
      idleCycle();
      checkOutput("pair_r8_q1");
      idleCycle();
      checkOutput("pair_r8_done");

      // Load-only write.
      rdInd0 = 4'd3;
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, 32'd44);
      checkOutput("mem_r3");
      idleCycle();
      checkOutput("mem_r3_done");

      // Dual traffic every cycle: third pair arrives while full and is lost.
      rdInd0 = 4'd5; rdInd1 = 4'd10;
      applyStimulus(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
      checkOutput("fill_1");
      applyStimulus(1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44);
      checkOutput("fill_2");
      applyStimulus(1'b1, 4'd5, 32'h55, 1'b1, 4'd9, 32'h99);
      checkOutput("fill_drop");
      checkValue("fill_drop.overflow_direct", DBITS'(overflow), 32'd1);
      applyStimulus(1'b1, 4'd10, 32'hAA, 1'b1, 4'd11, 32'hBB);
      checkOutput("fill_4");
      for (int i = 0; i < 4; i++) begin
         idleCycle();
         checkOutput("drain");
      end

      // Reset in the middle of traffic with three entries queued.
      rdInd0 = 4'd12; rdInd1 = 4'd15;
      applyStimulus(1'b1, 4'd12, 32'hC0, 1'b1, 4'd13, 32'hD0);
      applyStimulus(1'b1, 4'd14, 32'hE0, 1'b1, 4'd15, 32'hF0);
      checkOutput("pre_reset");
      reset_n = 1'b0;
      sb.delete();
      modelOverflow = 1'b0;
      #1;
      checkOutput("mid_reset");
      #1;
      reset_n = 1'b1;
      idleCycle();
      checkOutput("post_reset");

      checkValue("final_empty", DBITS'(sb.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
